// File: rtl/factor_checker_pkg.sv
// Shared constants for the factor checker: FSM state encodings and default width.
package factor_checker_pkg;

  localparam int FC_WIDTH = 32;

  // FSM state encodings
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_step
  import factor_checker_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  // Partial remainder is kept one bit wider so a divisor above 2^(WIDTH-1)
  // cannot overflow the shifted value.
  logic [WIDTH:0] t;
  logic           ge;

  assign t  = {acc, quo[WIDTH-1]};
  assign ge = (t >= {1'b0, divisor});

  // Restore or subtract; the difference is always < divisor so WIDTH bits suffice.
  always_comb begin
    acc_next = t[WIDTH-1:0];
    if (ge) acc_next = t[WIDTH-1:0] - divisor;
    quo_next = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/factor_checker.sv
// Checks a candidate factor of n: trivial cases resolve in one CHECK cycle,
// everything else runs a WIDTH-cycle restoring divide.
module factor_checker
  import factor_checker_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] factor,
  output logic             busy,
  output logic             done,
  output logic             is_factor,
  output logic             err,
  output logic [WIDTH-1:0] cofactor,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] n_q, d_q, acc, quo;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_next, quo_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .quo      (quo),
    .divisor  (d_q),
    .acc_next (acc_next),
    .quo_next (quo_next)
  );

  // Busy covers the operand check and the divide itself.
  assign busy = (state == S_CHECK) || (state == S_DIVIDE);

  // Done pulses the cycle after the DONE state, while already back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == S_DONE);
  end

  // Control FSM, operand latches, divider datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_q       <= '0;
      d_q       <= '0;
      acc       <= '0;
      quo       <= '0;
      count     <= '0;
      is_factor <= 1'b0;
      err       <= 1'b0;
      cofactor  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q   <= n;
            d_q   <= factor;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (d_q == '0 || n_q < WIDTH'(2)) begin
            err       <= 1'b1;
            is_factor <= 1'b0;
            cofactor  <= '0;
            remainder <= n_q;
            state     <= S_DONE;
          end else if (d_q > n_q) begin
            err       <= 1'b0;
            is_factor <= 1'b0;
            cofactor  <= '0;
            remainder <= n_q;
            state     <= S_DONE;
          end else if (d_q == WIDTH'(1)) begin
            err       <= 1'b0;
            is_factor <= 1'b0;
            cofactor  <= n_q;
            remainder <= '0;
            state     <= S_DONE;
          end else if (d_q == n_q) begin
            err       <= 1'b0;
            is_factor <= 1'b0;
            cofactor  <= WIDTH'(1);
            remainder <= '0;
            state     <= S_DONE;
          end else begin
            acc   <= '0;
            quo   <= n_q;
            count <= CW'(WIDTH - 1);
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          acc   <= acc_next;
          quo   <= quo_next;
          count <= count - CW'(1);
          if (count == '0) begin
            cofactor  <= quo_next;
            remainder <= acc_next;
            is_factor <= (acc_next == '0);
            err       <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factor_checker.sv
// Directed bench for factor_checker: latency, results, fast paths, ignored
// start while busy, back-to-back start and asynchronous abort.
module tb_factor_checker;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] n, factor;
  logic         busy, done, is_factor, err;
  logic [W-1:0] cofactor, remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  factor_checker #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n         (n),
    .factor    (factor),
    .busy      (busy),
    .done      (done),
    .is_factor (is_factor),
    .err       (err),
    .cofactor  (cofactor),
    .remainder (remainder)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] cof, input logic [W-1:0] rem,
                         input logic isf, input logic er);
    chk({tag, ".cof"}, cofactor, cof);
    chk({tag, ".rem"}, remainder, rem);
    chk({tag, ".isf"}, W'(is_factor), W'(isf));
    chk({tag, ".err"}, W'(err), W'(er));
  endtask

  // Call at a negedge. Ends at the negedge where done is first seen high.
  // inj_at >= 0 raises start (n=485, factor=3) for one cycle mid-operation.
  task automatic op(input logic [W-1:0] nv, input logic [W-1:0] fv, input int inj_at,
                    input int exp_lat, input string tag);
    int lat, bcnt;
    logic seen;
    n = nv; factor = fv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; n = $urandom; factor = $urandom;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin seen = 1'b1; break; end
      if (lat == inj_at) begin start = 1'b1; n = 485; factor = 3; end
      else start = 1'b0;
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, ".done"}, W'(seen), W'(1));
    chk({tag, ".lat"}, W'(lat), W'(exp_lat));
    chk({tag, ".busy"}, W'(bcnt), W'(exp_lat - 1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n = '0; factor = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.done", W'(done), W'(0));
    chk_res("rst", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Divide path
    op(485, 5, -1, 34, "div5");
    chk_res("div5", 97, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("div5.pulse", W'(done), W'(0));
    op(485, 7, -1, 34, "div7");
    chk_res("div7", 69, 2, 1'b0, 1'b0);

    // Fast paths
    @(negedge clk);
    op(485, 0, -1, 2, "f0");
    chk_res("f0", 0, 485, 1'b0, 1'b1);
    op(1, 1, -1, 2, "n1");
    chk_res("n1", 0, 1, 1'b0, 1'b1);
    op(485, 485, -1, 2, "fn");
    chk_res("fn", 1, 0, 1'b0, 1'b0);
    op(485, 1, -1, 2, "f1");
    chk_res("f1", 485, 0, 1'b0, 1'b0);
    op(485, 600, -1, 2, "fbig");
    chk_res("fbig", 0, 485, 1'b0, 1'b0);

    // Width extremes
    op(32'hFFFF_FFFF, 65537, -1, 34, "wmax");
    chk_res("wmax", 65535, 0, 1'b1, 1'b0);
    op(32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 2, "wgt");
    chk_res("wgt", 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op(32'hFFFF_FFFF, 32'h8000_0001, -1, 34, "whi");
    chk_res("whi", 1, 32'h7FFF_FFFE, 1'b0, 1'b0);

    // Start while busy is ignored; then back-to-back start in the done cycle
    op(485, 5, 10, 34, "ign");
    chk_res("ign", 97, 0, 1'b1, 1'b0);
    op(485, 7, -1, 34, "b2b");
    chk_res("b2b", 69, 2, 1'b0, 1'b0);

    // Asynchronous abort mid-divide
    @(negedge clk);
    n = 485; factor = 5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort.pre_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", W'(busy), W'(0));
    chk("abort.done", W'(done), W'(0));
    chk_res("abort", 0, 0, 1'b0, 1'b0);
    begin
      logic any_done;
      any_done = 1'b0;
      repeat (3) begin @(negedge clk); any_done |= done; end
      rst_n = 1'b1;
      repeat (40) begin @(negedge clk); any_done |= done; end
      chk("abort.nodone", W'(any_done), W'(0));
    end
    op(485, 97, -1, 34, "post");
    chk_res("post", 5, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
